// File: rtl/bcd_adder.sv
`default_nettype none
// ============================================================================
// Module      : bcd_adder
// Description : NDIG-digit ripple BCD adder with registered sum, decimal
//               carry out, valid and non-BCD-input error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_adder #(
    parameter int NDIG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [4*NDIG-1:0]   a,
    input  logic [4*NDIG-1:0]   b,
    input  logic                cin,
    output logic [4*NDIG-1:0]   sum,
    output logic                cout,
    output logic                out_valid,
    output logic                err
);

    logic [NDIG:0]          w_carry;
    logic [4*NDIG-1:0]      w_sum;
    logic [NDIG-1:0]        w_bad;

    logic [4*NDIG-1:0]      r_sum;
    logic                   r_cout;
    logic                   r_valid;
    logic                   r_err;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_digit
            logic [4:0] w_t;
            logic [3:0] w_adj;

            assign w_t   = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, w_carry[i]};
            // The 4-bit add wraps naturally, giving (t + 6) mod 16 even for t up to 31.
            assign w_adj = w_t[3:0] + 4'd6;

            assign w_carry[i+1]   = (w_t > 5'd9);
            assign w_sum[4*i +: 4] = w_carry[i+1] ? w_adj : w_t[3:0];
            assign w_bad[i]       = (a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[NDIG];
                r_err  <= |w_bad;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_adder
// Description : Scoreboard bench for bcd_adder, NDIG=1 and NDIG=2 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v1, c1, v2, c2;
    logic [3:0] a1, b1;
    logic [7:0] a2, b2;
    logic [3:0] s1;
    logic [7:0] s2;
    logic       co1, ov1, e1, co2, ov2, e2;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q2[$];

    bcd_adder #(.NDIG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .out_valid(ov1), .err(e1)
    );

    bcd_adder #(.NDIG(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .cin(c2),
        .sum(s2), .cout(co2), .out_valid(ov2), .err(e2)
    );

    // Reference: decimal arithmetic when every digit is legal BCD,
    // digit-by-digit rule for operands containing 10..15.
    function automatic exp_t model(input int ndig, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
        exp_t r;
        int   ad, bd, t, carry, da, db, tot, lim;
        bit   legal;
        r     = '0;
        legal = 1;
        da = 0; db = 0; lim = 1;
        for (int i = ndig - 1; i >= 0; i--) begin
            ad = int'((a >> (4*i)) & 32'hF);
            bd = int'((b >> (4*i)) & 32'hF);
            if (ad > 9 || bd > 9) legal = 0;
            da  = da * 10 + ad;
            db  = db * 10 + bd;
            lim = lim * 10;
        end
        r.err = !legal;
        if (legal) begin
            tot    = da + db + int'(cin);
            r.cout = (tot >= lim);
            tot    = tot % lim;
            for (int i = 0; i < ndig; i++) begin
                r.sum = r.sum | (32'(tot % 10) << (4*i));
                tot   = tot / 10;
            end
        end else begin
            carry = int'(cin);
            for (int i = 0; i < ndig; i++) begin
                ad = int'((a >> (4*i)) & 32'hF);
                bd = int'((b >> (4*i)) & 32'hF);
                t  = ad + bd + carry;
                if (t > 9) begin
                    r.sum = r.sum | (32'((t + 6) % 16) << (4*i));
                    carry = 1;
                end else begin
                    r.sum = r.sum | (32'(t) << (4*i));
                    carry = 0;
                end
            end
            r.cout = (carry != 0);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitors: pop one expectation per presented result.
    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL d1_unexpected: got out_valid=1 expected no result");
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("d1_sum", 32'(s1), e.sum);
                check("d1_cout", 32'(co1), 32'(e.cout));
                check("d1_err", 32'(e1), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL d2_unexpected: got out_valid=1 expected no result");
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("d2_sum", 32'(s2), e.sum);
                check("d2_cout", 32'(co2), 32'(e.cout));
                check("d2_err", 32'(e2), 32'(e.err));
            end
        end
    end

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(posedge clk); #1;
        v1 = 1'b1; a1 = a; b1 = b; c1 = c;
        q1.push_back(model(1, 32'(a), 32'(b), c));
    endtask

    task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(posedge clk); #1;
        v2 = 1'b1; a2 = a; b2 = b; c2 = c;
        q2.push_back(model(2, 32'(a), 32'(b), c));
    endtask

    task automatic idle2();
        @(posedge clk); #1;
        v2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 0; a1 = 4'h3; b1 = 4'h3; c1 = 0;
        v2 = 0; a2 = 8'h11; b2 = 8'h11; c2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_sum", 32'(s1), 0);
        check("rst_cout", 32'(co1), 0);
        check("rst_valid", 32'(ov1), 0);
        check("rst_err", 32'(e1), 0);
        check("rst_sum2", 32'(s2), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op1(4'(a), 4'(b), 1'(c));

        op1(4'h5, 4'h4, 1'b0);
        op1(4'h9, 4'h9, 1'b1);
        op1(4'hC, 4'h3, 1'b0);
        op1(4'hF, 4'hF, 1'b1);

        // Hold: idle cycle with fresh operands must not disturb the last result.
        op1(4'h3, 4'h4, 1'b0);
        @(posedge clk); #1;
        v1 = 1'b0; a1 = 4'hF; b1 = 4'hE; c1 = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("hold_valid", 32'(ov1), 0);
        check("hold_sum", 32'(s1), 32'h7);
        check("hold_cout", 32'(co1), 0);
        check("hold_err", 32'(e1), 0);

        // Reset beats a simultaneous operation.
        op1(4'h5, 4'h4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; v1 = 1'b1; a1 = 4'h7; b1 = 4'h8; c1 = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        check("rstv_sum", 32'(s1), 0);
        check("rstv_cout", 32'(co1), 0);
        check("rstv_valid", 32'(ov1), 0);
        check("rstv_err", 32'(e1), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; v1 = 1'b0;
        op1(4'h2, 4'h1, 1'b1);
        @(posedge clk); #1;
        v1 = 1'b0;

        op2(8'h99, 8'h01, 1'b0);
        op2(8'h45, 8'h38, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) begin
                idle2();
            end else if ($urandom_range(1) == 0) begin
                op2(8'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                op2({4'($urandom_range(9)), 4'($urandom_range(9))},
                    {4'($urandom_range(9)), 4'($urandom_range(9))}, 1'($urandom));
            end
        end
        @(posedge clk); #1;
        v2 = 1'b0;

        for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++)
            @(posedge clk);
        @(negedge clk); #1;
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d pending results expected 0", q1.size() + q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_adder.md
BCD_ADDER -- requirements
Module: bcd_adder

Interface
REQ-001 Parameter NDIG, default 1: number of BCD digits per operand; legal range 1..8.
REQ-002 The port list SHALL be, in order:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  4*NDIG  augend; digit i = a[4i+3:4i], digit 0 least significant.
- b  input  4*NDIG  addend; same packing as a.
- cin  input  1  carry into digit 0.
- sum  output  4*NDIG  registered BCD sum.
- cout  output  1  registered decimal carry out of the top digit.
- out_valid  output  1  registered; sum/cout/err hold a new result.
- err  output  1  registered; at least one input digit was above 9.

Function
REQ-003 All outputs SHALL be registered; latency is exactly 1 clock from an in_valid=1 sample to out_valid=1 with its result.
REQ-004 Per digit i, with c0 = cin, the block SHALL compute t = a_i + b_i + c_i as a 5-bit binary value (range 0..31).
REQ-005 If t > 9: sum_i = (t + 6) mod 16 and c_(i+1) = 1.
REQ-006 If t <= 9: sum_i = t and c_(i+1) = 0.
REQ-007 The carry SHALL ripple between digits combinationally within the same cycle; cout = c_NDIG.
REQ-008 Non-BCD input digits (10..15) SHALL be processed by REQ-004..006 unchanged, without saturation or clamping. Example: a=15, b=15, cin=1 gives t=31, sum=5, cout=1.
REQ-009 err SHALL be 1 for a result when any digit of a or b exceeds 9, and 0 otherwise.
REQ-010 When in_valid=1 at a clock edge (rst_n=1), sum, cout and err SHALL load the new result and out_valid SHALL go to 1.
REQ-011 When in_valid=0 at a clock edge (rst_n=1), out_valid SHALL go to 0; sum, cout and err SHALL hold their previous values.
REQ-012 Back-to-back in_valid=1 cycles SHALL each produce one result on consecutive cycles. There is no backpressure and no stall.
REQ-013 cin SHALL be ignored when in_valid=0.

Reset
REQ-014 rst_n is sampled only on the rising edge of clk; it has no asynchronous effect.
REQ-015 When rst_n=0 at a clock edge: sum=0, cout=0, out_valid=0, err=0.
REQ-016 Reset SHALL take priority over in_valid. An operation presented in the same cycle as reset is discarded and produces no result.
REQ-017 The first result after reset is deasserted SHALL come from the first in_valid=1 sample taken with rst_n=1.

Verification
REQ-018 NDIG=1: exhaustive sweep, a=0..15, b=0..15, cin=0 then cin=1, in_valid=1 each cycle -> every result matches REQ-004..006 and REQ-009, one cycle later.
REQ-019 a=4'h5, b=4'h4, cin=0 -> sum=4'h9, cout=0, err=0.
REQ-020 a=4'h9, b=4'h9, cin=1 -> sum=4'h9, cout=1, err=0.
REQ-021 a=4'hC, b=4'h3, cin=0 -> t=15, sum=4'h5, cout=1, err=1.
REQ-022 NDIG=2: a=8'h99, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'h45, b=8'h38, cin=1 -> sum=8'h84, cout=0.
REQ-023 Reset and valid gaps:
- rst_n=0 together with in_valid=1 (a=4'h7, b=4'h8) -> next cycle sum=0, cout=0, out_valid=0.
- in_valid=0 cycle -> out_valid=0, previous sum held.
